// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2-to-Z88 keyboard bridge: decoder states,
// scancode prefixes and the Z88 matrix keymap table.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam int KEY_COUNT = 64;

  // Entry i is the {ext, scancode} that drives matrix bit i (row*8 + column).
  localparam logic [8:0] KEYMAP [0:KEY_COUNT-1] = '{
    // row 0: 8 7 N H Y 6 ENTER DEL
    9'h03E, 9'h03D, 9'h031, 9'h033, 9'h035, 9'h036, 9'h05A, 9'h066,
    // row 1: I U B G T 5 LEFT backslash
    9'h043, 9'h03C, 9'h032, 9'h034, 9'h02C, 9'h02E, 9'h16B, 9'h05D,
    // row 2: O J V F R 4 RIGHT =
    9'h044, 9'h03B, 9'h02A, 9'h02B, 9'h02D, 9'h025, 9'h174, 9'h055,
    // row 3: 9 K C D E 3 DOWN -
    9'h046, 9'h042, 9'h021, 9'h023, 9'h024, 9'h026, 9'h172, 9'h04E,
    // row 4: P M X S W 2 UP [
    9'h04D, 9'h03A, 9'h022, 9'h01B, 9'h01D, 9'h01E, 9'h175, 9'h054,
    // row 5: 0 L Z A Q 1 SPACE ]
    9'h045, 9'h04B, 9'h01A, 9'h01C, 9'h015, 9'h016, 9'h029, 9'h05B,
    // row 6: ; ' , . / TAB LSHIFT ESC
    9'h04C, 9'h052, 9'h041, 9'h049, 9'h04A, 9'h00D, 9'h012, 9'h076,
    // row 7: CAPS MENU HELP INDEX DIAMOND SQUARE ` RSHIFT
    9'h058, 9'h005, 9'h006, 9'h004, 9'h014, 9'h011, 9'h00E, 9'h059
  };

  function automatic logic [8:0] make_code(input logic ext, input logic [7:0] sc);
    return {ext, sc};
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scancode lookup: {ext, byte} -> Z88 matrix bit index.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [8:0] code,
  output logic       valid,
  output logic [5:0] index
);

  logic [KEY_COUNT-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_COUNT; gi++) begin : g_match
      assign hit[gi] = (code == KEYMAP[gi]);
    end
  endgenerate

  // Table entries are unique, so at most one hit is set and OR-ing is exact.
  always_comb begin
    index = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (hit[i]) index = index | 6'(i);
    end
  end

  assign valid = |hit;

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 keyboard receiver and scancode decoder driving an active-low
// 64-bit Z88 keyboard matrix.
module ps2_kbd_matrix
  import ps2_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2clk,
  input  logic        ps2dat,
  output logic [63:0] kbmat_out,
  output logic        rx_err
);

  logic [1:0]  clk_sync_reg;
  logic [1:0]  dat_sync_reg;
  logic        clk_prev_reg;
  logic        fall;

  logic [3:0]  bit_cnt_reg;
  logic [9:0]  shift_reg;
  logic [10:0] frame_full;
  logic        frame_ok;
  logic [15:0] timeout_reg;

  logic [7:0]  byte_reg;
  logic        strobe_reg;
  logic        frame_err_reg;
  logic        rx_err_reg;

  kb_state_t   state_reg;
  logic [63:0] kbmat_reg;
  logic        ext;
  logic        is_prefix;
  logic        key_valid;
  logic [5:0]  key_index;

  // Synchronizers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], ps2clk};
      dat_sync_reg <= {dat_sync_reg[0], ps2dat};
      clk_prev_reg <= clk_sync_reg[1];
    end
  end

  assign fall = clk_prev_reg & ~clk_sync_reg[1];

  // Bits arrive LSB first; after ten shifts shift_reg[0] holds the start bit.
  assign frame_full = {dat_sync_reg[1], shift_reg};
  assign frame_ok   = (frame_full[0] == 1'b0) &&
                      (^frame_full[9:1] == 1'b1) &&
                      (frame_full[10] == 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      timeout_reg   <= '0;
      byte_reg      <= '0;
      strobe_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      rx_err_reg    <= 1'b0;
    end else begin
      strobe_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      rx_err_reg    <= 1'b0;
      if (fall) begin
        timeout_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= '0;
          shift_reg   <= '0;
          if (frame_ok) begin
            byte_reg   <= frame_full[8:1];
            strobe_reg <= 1'b1;
          end else begin
            frame_err_reg <= 1'b1;
            rx_err_reg    <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          shift_reg   <= frame_full[10:1];
        end
      end else if (bit_cnt_reg != 4'd0) begin
        // Dropping bit_cnt to zero stops the count, so only one pulse fires.
        if (timeout_reg >= TIMEOUT_CYCLES - 16'd1) begin
          bit_cnt_reg <= '0;
          shift_reg   <= '0;
          rx_err_reg  <= 1'b1;
        end
        if (timeout_reg != 16'hFFFF) timeout_reg <= timeout_reg + 16'd1;
      end
    end
  end

  assign ext       = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
  assign is_prefix = (byte_reg == PFX_EXT) || (byte_reg == PFX_BRK);

  ps2_keymap u_keymap (
    .code  (make_code(ext, byte_reg)),
    .valid (key_valid),
    .index (key_index)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      kbmat_reg <= '1;
    end else if (frame_err_reg) begin
      state_reg <= ST_IDLE;
    end else if (strobe_reg) begin
      state_reg <= ST_IDLE;
      case (state_reg)
        ST_IDLE: begin
          if (byte_reg == PFX_EXT)      state_reg <= ST_EXT;
          else if (byte_reg == PFX_BRK) state_reg <= ST_BRK;
          else if (key_valid)           kbmat_reg[key_index] <= 1'b0;
        end
        ST_EXT: begin
          if (byte_reg == PFX_BRK) state_reg <= ST_EXT_BRK;
          else if (key_valid)      kbmat_reg[key_index] <= 1'b0;
        end
        default: begin
          if (!is_prefix && key_valid) kbmat_reg[key_index] <= 1'b1;
        end
      endcase
    end
  end

  assign kbmat_out = kbmat_reg;
  assign rx_err    = rx_err_reg;

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Scoreboard bench: stimulus pushes expected matrix/error events, a monitor
// pops them whenever the DUT's matrix changes or rx_err pulses.
module tb_ps2_kbd_matrix;

  localparam logic [15:0] TMO = 16'd200;
  localparam int EK_NONE = 0;
  localparam int EK_MAT  = 1;
  localparam int EK_ERR  = 2;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2clk = 1'b1;
  logic        ps2dat = 1'b1;
  logic [63:0] kbmat_out;
  logic        rx_err;

  typedef struct {
    bit          is_err;
    logic [63:0] mat;
    int          cyc;
    int          slack;   // -1: timing not checked
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [63:0] model_mat = ALL1;
  logic [63:0] mon_prev = ALL1;

  ps2_kbd_matrix #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .kbmat_out (kbmat_out),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_bit(input logic b, input int kind, output int fall_cyc);
    ps2dat = b;
    repeat (2) @(negedge clk);
    ps2clk = 1'b0;
    fall_cyc = cyc;
    if (kind == EK_MAT)      sb_q.push_back('{1'b0, model_mat, cyc + 4, 0});
    else if (kind == EK_ERR) sb_q.push_back('{1'b1, model_mat, cyc + 3, 0});
    repeat (5) @(negedge clk);
    ps2clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good, input int kind);
    logic [10:0] f;
    int fc;
    f = {1'b1, (good ? ~^d : ^d), d, 1'b0};
    $display("txn frame byte=%h good_parity=%0d kind=%0d", d, good, kind);
    for (int i = 0; i < 11; i++) drive_bit(f[i], (i == 10) ? kind : EK_NONE, fc);
    ps2dat = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits, output int last_fall);
    logic [10:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    last_fall = 0;
    $display("txn partial byte=%h bits=%0d", d, nbits);
    for (int i = 0; i < nbits; i++) drive_bit(f[i], EK_NONE, last_fall);
    ps2dat = 1'b1;
  endtask

  task automatic check_idle(input string name);
    repeat (20) @(negedge clk);
    checks++;
    if (kbmat_out !== model_mat) begin
      failures++;
      $display("FAIL %s_matrix got=%h exp=%h", name, kbmat_out, model_mat);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got=%0d exp=0", name, sb_q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    wait (reset_n === 1'b1);
    forever begin
      @(negedge clk);
      if (rx_err === 1'b1 || kbmat_out !== mon_prev) begin
        $display("txn event cyc=%0d rx_err=%b kbmat=%h", cyc, rx_err, kbmat_out);
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d rx_err=%b kbmat=%h", cyc, rx_err, kbmat_out);
        end else begin
          e = sb_q.pop_front();
          if (rx_err !== e.is_err || kbmat_out !== e.mat) begin
            failures++;
            $display("FAIL event_value got err=%b mat=%h exp err=%b mat=%h",
                     rx_err, kbmat_out, e.is_err, e.mat);
          end
          checks++;
          if (e.slack >= 0 && (cyc < e.cyc - e.slack || cyc > e.cyc + e.slack)) begin
            failures++;
            $display("FAIL event_latency got cyc=%0d exp cyc=%0d+-%0d", cyc, e.cyc, e.slack);
          end
        end
        mon_prev = kbmat_out;
      end
    end
  end

  initial begin : stimulus
    int lf;
    repeat (3) @(negedge clk);
    checks++;
    if (kbmat_out !== ALL1) begin
      failures++;
      $display("FAIL reset_matrix got=%h exp=%h", kbmat_out, ALL1);
    end
    checks++;
    if (rx_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rx_err got=%b exp=0", rx_err);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Enter make and break
    model_mat[6] = 1'b0; send_frame(8'h5A, 1, EK_MAT);
    send_frame(8'hF0, 1, EK_NONE);
    model_mat[6] = 1'b1; send_frame(8'h5A, 1, EK_MAT);
    check_idle("enter");

    // Extended Up make/break, bare 0x75 unmapped
    send_frame(8'hE0, 1, EK_NONE);
    model_mat[38] = 1'b0; send_frame(8'h75, 1, EK_MAT);
    send_frame(8'hE0, 1, EK_NONE);
    send_frame(8'hF0, 1, EK_NONE);
    model_mat[38] = 1'b1; send_frame(8'h75, 1, EK_MAT);
    send_frame(8'h75, 1, EK_NONE);
    check_idle("up");

    // Bad parity, then a good LShift
    send_frame(8'h12, 0, EK_ERR);
    check_idle("badpar");
    model_mat[54] = 1'b0; send_frame(8'h12, 1, EK_MAT);

    // Partial frame abandoned by timeout, then Space
    send_partial(8'h29, 5, lf);
    sb_q.push_back('{1'b1, model_mat, lf + 3 + int'(TMO), 2});
    repeat (int'(TMO) + 10) @(negedge clk);
    check_idle("timeout");
    model_mat[46] = 1'b0; send_frame(8'h29, 1, EK_MAT);

    // Unmapped bytes and repeated make change nothing
    send_frame(8'hAA, 1, EK_NONE);
    send_frame(8'hE1, 1, EK_NONE);
    send_frame(8'h29, 1, EK_NONE);
    check_idle("unmapped");

    // A frame error drops a pending break prefix
    send_frame(8'hF0, 1, EK_NONE);
    send_frame(8'h33, 0, EK_ERR);
    model_mat[6] = 1'b0; send_frame(8'h5A, 1, EK_MAT);
    send_frame(8'hF0, 1, EK_NONE);
    model_mat[6] = 1'b1; send_frame(8'h5A, 1, EK_MAT);
    check_idle("prefix_clear");

    // Reset in the middle of an F0 frame
    send_partial(8'hF0, 4, lf);
    #2;
    sb_q.push_back('{1'b0, ALL1, 0, -1});
    reset_n = 1'b0;
    #1;
    checks++;
    if (kbmat_out !== ALL1) begin
      failures++;
      $display("FAIL midreset_matrix got=%h exp=%h", kbmat_out, ALL1);
    end
    checks++;
    if (rx_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_rx_err got=%b exp=0", rx_err);
    end
    model_mat = ALL1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    model_mat[7] = 1'b0; send_frame(8'h66, 1, EK_MAT);
    check_idle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_matrix.md
PS2_KBD_MATRIX -- requirements
Module: ps2_kbd_matrix

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd20000: number of clk cycles without a PS/2 clock falling edge after which a partial frame is abandoned.
REQ-002 clk  input  1: single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1: reset, asynchronous assert, active-low.
REQ-004 ps2clk  input  1: PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 ps2dat  input  1: PS/2 data from the keyboard, asynchronous to clk.
REQ-006 kbmat_out  output  64: Z88 keyboard matrix, index = row*8 + column; bit 0 = key held, 1 = key released.
REQ-007 rx_err  output  1: one-cycle pulse on a frame error (bad start bit, parity or stop bit) or on a timeout.

Function
REQ-008 ps2clk and ps2dat SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized ps2clk (previous 1, current 0).
REQ-009 On each detected falling edge, the receiver SHALL sample synchronized ps2dat into an 11-bit frame, ordered start, d0..d7 (LSB first), odd parity, stop.
REQ-010 Receiver bit counter SHALL run 0..10 and return to 0 after bit 10.
- Frame is valid only if: start=0, XOR of d0..d7 and parity = 1, stop=1.
- Valid frame SHALL raise an internal byte strobe for exactly one cycle, 1 cycle after the stop-bit edge.
REQ-011 Invalid frame SHALL be discarded, pulse rx_err, and clear the decoder prefix flags.
REQ-012 Timeout counter SHALL reset on every falling edge and count only while the bit counter is non-zero.
- Reaching TIMEOUT_CYCLES SHALL reset the bit counter to 0 and pulse rx_err.
- Counter SHALL saturate, never wrap.
REQ-013 Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
REQ-014 Decoder transitions on a byte strobe:
- 0xE0 in IDLE -> EXT.
- 0xF0 in IDLE -> BRK.
- 0xF0 in EXT -> EXT_BRK.
- Any other byte: perform the key action, then -> IDLE.
- 0xE0 or 0xF0 received in BRK or EXT_BRK -> IDLE, no action.
REQ-015 Key action SHALL look up the 9-bit code {ext, byte} in the keymap, which returns valid + 6-bit index.
- Make (IDLE/EXT): clear kbmat_out[index].
- Break (BRK/EXT_BRK): set kbmat_out[index].
- valid=0: no change.
REQ-016 kbmat_out SHALL update in the cycle after the byte strobe (total latency = 2 clk cycles from the stop-bit edge); all other bits SHALL be unchanged.
REQ-017 Byte 0xAA (self-test pass) and byte 0xE1 SHALL be unmapped (no matrix change); repeated make codes SHALL be idempotent.
REQ-018 Keymap minimum entries:
- 0x5A (Enter) -> 6.
- 0x66 (Backspace) -> 7 (DEL).
- 0x29 (Space) -> 46.
- 0x12 (LShift) -> 54.
- 0x59 (RShift) -> 63.
- E0+0x75 (Up) -> 38.
- E0+0x72 (Down) -> 30.
- Remaining entries per the Z88 matrix layout in the package.

Reset
REQ-019 While reset_n=0, the block SHALL hold:
- kbmat_out = 64'hFFFF_FFFF_FFFF_FFFF;
- rx_err = 0;
- FSM = IDLE;
- bit counter, timeout counter and shift register = 0;
- synchronizer flops = 1.
REQ-020 A reset asserted mid-frame SHALL discard the partial frame; the first falling edge after release SHALL be treated as a start bit.

Structure
REQ-021 Shared package ps2_pkg SHALL hold the decoder state encoding, the prefix constants 0xE0/0xF0, and the keymap table contents.
REQ-022 Keymap SHALL be a combinational sub-module ps2_keymap (input 9-bit code; outputs valid, index[5:0]); the receiver and the FSM SHALL stay in ps2_kbd_matrix.

Verification
REQ-023 Send frame 0x5A with correct parity -> kbmat_out[6]=0 two cycles after the stop edge; then send F0,5A -> kbmat_out[6]=1; no other bit ever changes.
REQ-024 Send E0,75 -> bit 38 = 0; send E0,F0,75 -> bit 38 = 1; send bare 0x75 -> no change (unmapped).
REQ-025 Send 0x12 with inverted parity -> rx_err pulses for 1 cycle, kbmat_out stays all-ones; the next good 0x12 -> bit 54 = 0.
REQ-026 Send 5 bits of a frame, then idle for TIMEOUT_CYCLES+10 -> exactly one rx_err pulse; the next full frame 0x29 -> bit 46 = 0.
REQ-027 Press 0x12 and 0x29 together, assert reset_n=0 mid-frame of F0 -> kbmat_out = all-ones immediately; after release, 0x66 -> only bit 7 = 0.
